// File: rtl/spi_axi_wr_sink.sv
// AXI4 write slave terminating the SPI receive path into a byte register bank.
// One AW phase, a wlast-terminated burst of byte beats, then a B response.
module spi_axi_wr_sink #(
  parameter int          DEPTH     = 256,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic                     axi_aclk,
  input  logic                     axi_areset,
  input  logic [15:0]              axi_awaddr,
  input  logic                     axi_awvalid,
  output logic                     axi_awready,
  input  logic [7:0]               axi_wdata,
  input  logic                     axi_wvalid,
  output logic                     axi_wready,
  input  logic                     axi_wlast,
  output logic [1:0]               axi_bresp,
  output logic                     axi_bvalid,
  input  logic                     axi_bready,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data,
  output logic                     wr_done,
  output logic [15:0]              wr_count
);

  localparam int AW = $clog2(DEPTH);

  // Bank window in 17 bits so a window touching FFFF does not overflow.
  localparam logic [16:0] LO = {1'b0, BASE_ADDR};
  localparam logic [16:0] HI = LO + 17'(DEPTH);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_t;

  state_t state;
  state_t state_n;

  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;
  logic          in_range;
  logic [16:0]   addr_x;
  logic [15:0]   addr_q;
  logic [15:0]   beat_cnt;
  logic [15:0]   beat_cnt_n;
  logic          err;
  logic [AW-1:0] idx;

  logic [7:0] bank [DEPTH];

  assign addr_x   = {1'b0, addr_q};
  assign in_range = (addr_x >= LO) && (addr_x < HI);
  assign idx      = AW'(addr_q - BASE_ADDR);

  assign beat_cnt_n = (beat_cnt == 16'hFFFF) ? beat_cnt
                                             : beat_cnt + 16'd1;

  // Handshakes are qualified by state so a stale ready never fires.
  always_comb begin
    aw_hs = 1'b0;
    w_hs  = 1'b0;
    b_hs  = 1'b0;
    unique case (state)
      IDLE: aw_hs = axi_awvalid & axi_awready;
      DATA: w_hs  = axi_wvalid & axi_wready;
      RESP: b_hs  = axi_bvalid & axi_bready;
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (aw_hs) state_n = DATA;
      DATA: if (w_hs && axi_wlast) state_n = RESP;
      RESP: if (b_hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) state <= IDLE;
    else            state <= state_n;
  end

  // Registered channel readies/valids follow the next state.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= OKAY;
      wr_done     <= 1'b0;
      wr_count    <= 16'h0000;
    end else begin
      axi_awready <= (state_n == IDLE);
      axi_wready  <= (state_n == DATA);
      axi_bvalid  <= (state_n == RESP);
      wr_done     <= b_hs;
      if (w_hs && axi_wlast)
        axi_bresp <= (err || !in_range) ? SLVERR : OKAY;
      if (b_hs)
        wr_count <= beat_cnt;
    end
  end

  // Burst address, beat counter and sticky range error.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      addr_q   <= 16'h0000;
      beat_cnt <= 16'h0000;
      err      <= 1'b0;
    end else if (aw_hs) begin
      addr_q   <= axi_awaddr;
      beat_cnt <= 16'h0000;
      err      <= 1'b0;
    end else if (w_hs) begin
      addr_q   <= addr_q + 16'd1;
      beat_cnt <= beat_cnt_n;
      if (!in_range) err <= 1'b1;
    end
  end

  // Register bank: cleared on reset, one byte per accepted in-range beat.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= 8'h00;
    end else if (w_hs && in_range) begin
      bank[idx] <= axi_wdata;
    end
  end

  // Read port; a colliding write shows up one cycle later.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) rd_data <= 8'h00;
    else            rd_data <= bank[rd_addr];
  end

endmodule

// File: tb/tb_spi_axi_wr_sink.sv
// Directed bench for spi_axi_wr_sink with write/response scoreboards.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_spi_axi_wr_sink;

  logic        clk;
  logic        rst;
  logic [15:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [7:0]  wdata;
  logic        wvalid;
  logic        wready;
  logic        wlast;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        wr_done;
  logic [15:0] wr_count;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [1:0]  resp;
    logic [15:0] cnt;
  } b_t;

  wr_t wq[$];
  b_t  bq[$];

  logic [15:0] m_addr;
  logic [15:0] m_cnt;
  logic        m_err;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  spi_axi_wr_sink dut (
    .axi_aclk    (clk),
    .axi_areset  (rst),
    .axi_awaddr  (awaddr),
    .axi_awvalid (awvalid),
    .axi_awready (awready),
    .axi_wdata   (wdata),
    .axi_wvalid  (wvalid),
    .axi_wready  (wready),
    .axi_wlast   (wlast),
    .axi_bresp   (bresp),
    .axi_bvalid  (bvalid),
    .axi_bready  (bready),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_done     (wr_done),
    .wr_count    (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_aw(input logic [15:0] a);
    m_addr = a;
    m_cnt  = 16'h0;
    m_err  = 1'b0;
  endtask

  task automatic model_beat(input logic [7:0] d, input logic last);
    wr_t w;
    b_t  b;
    if (m_addr < 16'd256) begin
      w.idx  = m_addr[7:0];
      w.data = d;
      wq.push_back(w);
    end else begin
      m_err = 1'b1;
    end
    m_addr = m_addr + 16'd1;
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (last) begin
      b.resp = m_err ? 2'b10 : 2'b00;
      b.cnt  = m_cnt;
      bq.push_back(b);
    end
  endtask

  task automatic do_aw(input logic [15:0] a);
    int n;
    awaddr  = a;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin
      tick();
      n++;
    end
    check("aw_wait", {15'h0, awready}, 16'h1);
    tick();
    awvalid = 1'b0;
    model_aw(a);
  endtask

  task automatic do_beat(input logic [7:0] d, input logic last);
    int n;
    wdata  = d;
    wlast  = last;
    wvalid = 1'b1;
    n = 0;
    while (!wready && n < 50) begin
      tick();
      n++;
    end
    check("w_wait", {15'h0, wready}, 16'h1);
    tick();
    wvalid = 1'b0;
    wlast  = 1'b0;
    model_beat(d, last);
  endtask

  task automatic wait_b();
    int n;
    b_t b;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin
      tick();
      n++;
    end
    check("b_wait", {15'h0, bvalid}, 16'h1);
    if (bq.size() == 0) begin
      check("b_queue_empty", 16'(bq.size()), 16'h1);
      b.resp = 2'b00;
      b.cnt  = 16'h0;
    end else begin
      b = bq.pop_front();
    end
    check("bresp", {14'h0, bresp}, {14'h0, b.resp});
    tick();
    bready = 1'b0;
    check("wr_done_pulse", {15'h0, wr_done}, 16'h1);
    check("wr_count", wr_count, b.cnt);
    check("bvalid_drop", {15'h0, bvalid}, 16'h0);
    check("awready_after_b", {15'h0, awready}, 16'h1);
    check("wready_after_b", {15'h0, wready}, 16'h0);
    tick();
    check("wr_done_end", {15'h0, wr_done}, 16'h0);
    check("wr_count_held", wr_count, b.cnt);
  endtask

  task automatic drain();
    wr_t w;
    while (wq.size() > 0) begin
      w = wq.pop_front();
      rd_addr = w.idx;
      tick();
      check($sformatf("bank[%02h]", w.idx), {8'h0, rd_data},
            {8'h0, w.data});
    end
  endtask

  task automatic expect_byte(input logic [7:0] i, input logic [7:0] d);
    wr_t w;
    w.idx  = i;
    w.data = d;
    wq.push_back(w);
  endtask

  initial begin
    rst     = 1'b1;
    awaddr  = 16'h0;
    awvalid = 1'b0;
    wdata   = 8'h0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    bready  = 1'b0;
    rd_addr = 8'h0;
    model_aw(16'h0);

    // Reset state
    repeat (3) tick();
    check("rst_awready", {15'h0, awready}, 16'h0);
    check("rst_wready", {15'h0, wready}, 16'h0);
    check("rst_bvalid", {15'h0, bvalid}, 16'h0);
    check("rst_bresp", {14'h0, bresp}, 16'h0);
    check("rst_wr_done", {15'h0, wr_done}, 16'h0);
    check("rst_wr_count", wr_count, 16'h0);
    check("rst_rd_data", {8'h0, rd_data}, 16'h0);
    rst = 1'b0;
    tick();
    check("awready_first_edge", {15'h0, awready}, 16'h1);

    // Three-beat burst at 0x10
    do_aw(16'h0010);
    do_beat(8'h11, 1'b0);
    do_beat(8'h22, 1'b0);
    do_beat(8'h33, 1'b1);
    wait_b();
    drain();

    // Burst straddling the bank end
    do_aw(16'h00FE);
    do_beat(8'hAA, 1'b0);
    do_beat(8'hBB, 1'b0);
    do_beat(8'hCC, 1'b0);
    do_beat(8'hDD, 1'b1);
    wait_b();
    expect_byte(8'h00, 8'h00);
    expect_byte(8'h01, 8'h00);
    drain();

    // B back-pressure with a stalled AW behind it
    do_aw(16'h0020);
    do_beat(8'h77, 1'b1);
    awaddr  = 16'h0030;
    awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", {15'h0, bvalid}, 16'h1);
      check("bp_awready", {15'h0, awready}, 16'h0);
      tick();
    end
    model_aw(16'h0000);
    wait_b();
    model_aw(16'h0030);
    check("aw2_accepted", {15'h0, wready}, 16'h1);
    check("aw2_awready", {15'h0, awready}, 16'h0);

    // Gapped beats with AW held during DATA
    awaddr = 16'h0040;
    wvalid = 1'b1;
    wdata  = 8'h01;
    wlast  = 1'b0;
    tick();
    model_beat(8'h01, 1'b0);
    check("gap_awready0", {15'h0, awready}, 16'h0);
    wvalid = 1'b0;
    wdata  = 8'hEE;
    wlast  = 1'b1;
    tick();
    check("gap_awready1", {15'h0, awready}, 16'h0);
    check("gap_wready", {15'h0, wready}, 16'h1);
    wvalid = 1'b1;
    wdata  = 8'h02;
    wlast  = 1'b1;
    tick();
    model_beat(8'h02, 1'b1);
    wvalid = 1'b0;
    wlast  = 1'b0;
    check("gap_bvalid", {15'h0, bvalid}, 16'h1);
    check("gap_awready2", {15'h0, awready}, 16'h0);
    check("gap_wready_drop", {15'h0, wready}, 16'h0);
    wait_b();
    model_aw(16'h0040);
    awvalid = 1'b0;
    check("aw3_accepted", {15'h0, wready}, 16'h1);
    do_beat(8'h44, 1'b1);
    wait_b();
    expect_byte(8'h32, 8'h00);
    drain();

    // Read colliding with a write of 0x5A at 0x10
    do_aw(16'h0010);
    check("col_wready", {15'h0, wready}, 16'h1);
    rd_addr = 8'h10;
    wvalid  = 1'b1;
    wdata   = 8'h5A;
    wlast   = 1'b1;
    tick();
    model_beat(8'h5A, 1'b1);
    wvalid = 1'b0;
    wlast  = 1'b0;
    check("col_old", {8'h0, rd_data}, 16'h0011);
    tick();
    check("col_new", {8'h0, rd_data}, 16'h005A);
    wait_b();
    drain();

    // Reset in the middle of a four-beat burst
    do_aw(16'h0050);
    do_beat(8'h01, 1'b0);
    do_beat(8'h02, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wq.delete();
    bq.delete();
    check("mid_awready", {15'h0, awready}, 16'h0);
    check("mid_wready", {15'h0, wready}, 16'h0);
    check("mid_bvalid", {15'h0, bvalid}, 16'h0);
    check("mid_bresp", {14'h0, bresp}, 16'h0);
    check("mid_wr_done", {15'h0, wr_done}, 16'h0);
    check("mid_wr_count", wr_count, 16'h0);
    check("mid_rd_data", {8'h0, rd_data}, 16'h0);
    expect_byte(8'h50, 8'h00);
    expect_byte(8'h51, 8'h00);
    expect_byte(8'h10, 8'h00);
    expect_byte(8'hFE, 8'h00);
    drain();
    do_aw(16'h0060);
    do_beat(8'h9A, 1'b0);
    do_beat(8'h9B, 1'b1);
    wait_b();
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
